cascade_slave_responder: RTL and testbench

Slave-side INTA sequencer for the cascaded 8259-style PIC. It counts CPU interrupt-acknowledge pulses, samples the master's cascade code, and decides whether this slave owns the acknowledge. If it does, it requests the ISR set and places the vector byte(s) on the data bus during the correct INTA pulse(s). It sits between the bus/INTA front end, the priority resolver and the ISR register.

---
 rtl/cascade_slave_responder.sv | 207 ++++++++++++++++++++
 tb/tb_cascade_slave_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_slave_responder.sv
// cascade_slave_responder
// Slave-side INTA sequencer for a cascaded 8259-style PIC. It counts the CPU
// interrupt-acknowledge pulses and samples the master's cascade code on the
// first pulse to decide whether this slave owns the acknowledge. If it does,
// it requests the ISR set and drives the vector byte(s) during the correct
// pulse(s). Define AEOI_EN to add the aeoi_flag input and the auto_eoi output,
// which pulse after the final INTA pulse so the ISR bit is cleared
// automatically.
module cascade_slave_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inta_n,
  input  logic       sp_neg,
  input  logic       single_mode_flag,
  input  logic       mode_8086,
  input  logic [2:0] my_slave_id,
  input  logic [2:0] cascading_lines,
  input  logic       int_pending,
  input  logic [2:0] int_level,
  input  logic [7:0] icw2,
  input  logic [2:0] icw1_addr,
  output logic [7:0] data_out,
  output logic       data_drive,
  output logic       isr_set,
  output logic [2:0] isr_level,
`ifdef AEOI_EN
  input  logic       aeoi_flag,
  output logic       auto_eoi,
`endif
  output logic       selected
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    G1,
    P2,
    G2,
    P3
  } state_t;

  // The gap counter reaches this value on the last idle clock that is allowed.
  localparam logic [15:0] GapLast = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        intaNPrev_q;
  logic        pend_q;
  logic        mode_q;
  logic [15:0] gapCount_q;
  logic [7:0]  dataOut_q;
  logic        dataDrive_q;
  logic        isrSet_q;
  logic [2:0]  isrLevel_q;
  logic        selected_q;
`ifdef AEOI_EN
  logic        autoEoi_q;
`endif

  logic fall;
  logic rise;
  logic inert;
  logic idMatch;

  assign fall    = intaNPrev_q & ~inta_n;
  assign rise    = ~intaNPrev_q & inta_n;
  assign inert   = sp_neg | single_mode_flag;
  assign idMatch = (cascading_lines == my_slave_id);

  // Registered copy of the strobe; resets high so no edge is seen out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intaNPrev_q <= 1'b1;
    end else begin
      intaNPrev_q <= inta_n;
    end
  end

  // Acknowledge sequencer: pulse/gap tracking, ownership decision, vector drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      mode_q      <= 1'b0;
      gapCount_q  <= 16'd0;
      dataOut_q   <= 8'h00;
      dataDrive_q <= 1'b0;
      isrSet_q    <= 1'b0;
      isrLevel_q  <= 3'd0;
      selected_q  <= 1'b0;
`ifdef AEOI_EN
      autoEoi_q   <= 1'b0;
`endif
    end else begin
      isrSet_q <= 1'b0;
`ifdef AEOI_EN
      autoEoi_q <= 1'b0;
`endif
      if (inert) begin
        state_q     <= IDLE;
        pend_q      <= 1'b0;
        mode_q      <= 1'b0;
        gapCount_q  <= 16'd0;
        dataOut_q   <= 8'h00;
        dataDrive_q <= 1'b0;
        isrLevel_q  <= 3'd0;
        selected_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            dataOut_q   <= 8'h00;
            dataDrive_q <= 1'b0;
            selected_q  <= 1'b0;
            if (fall) begin
              state_q    <= P1;
              isrLevel_q <= int_level;
              pend_q     <= int_pending;
              mode_q     <= mode_8086;
            end
          end
          P1: begin
            if (rise) begin
              state_q    <= G1;
              gapCount_q <= 16'd0;
              selected_q <= pend_q & idMatch;
              isrSet_q   <= pend_q & idMatch;
            end
          end
          G1: begin
            if (fall) begin
              state_q     <= P2;
              dataDrive_q <= selected_q;
              if (!selected_q) begin
                dataOut_q <= 8'h00;
              end else if (mode_q) begin
                dataOut_q <= {icw2[7:3], isrLevel_q};
              end else begin
                dataOut_q <= {icw1_addr, isrLevel_q, 2'b00};
              end
            end else if (gapCount_q == GapLast) begin
              state_q    <= IDLE;
              selected_q <= 1'b0;
            end else begin
              gapCount_q <= gapCount_q + 16'd1;
            end
          end
          P2: begin
            if (rise) begin
              dataOut_q   <= 8'h00;
              dataDrive_q <= 1'b0;
              if (mode_q) begin
                state_q    <= IDLE;
                selected_q <= 1'b0;
`ifdef AEOI_EN
                autoEoi_q  <= selected_q & aeoi_flag;
`endif
              end else begin
                state_q    <= G2;
                gapCount_q <= 16'd0;
              end
            end
          end
          G2: begin
            if (fall) begin
              state_q     <= P3;
              dataDrive_q <= selected_q & ~mode_q;
              dataOut_q   <= (selected_q & ~mode_q) ? icw2 : 8'h00;
            end else if (gapCount_q == GapLast) begin
              state_q    <= IDLE;
              selected_q <= 1'b0;
            end else begin
              gapCount_q <= gapCount_q + 16'd1;
            end
          end
          P3: begin
            if (rise) begin
              state_q     <= IDLE;
              dataOut_q   <= 8'h00;
              dataDrive_q <= 1'b0;
              selected_q  <= 1'b0;
`ifdef AEOI_EN
              autoEoi_q   <= selected_q & aeoi_flag;
`endif
            end
          end
          default: begin
            state_q     <= IDLE;
            dataOut_q   <= 8'h00;
            dataDrive_q <= 1'b0;
            selected_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = dataOut_q;
  assign data_drive = dataDrive_q;
  assign isr_set    = isrSet_q;
  assign isr_level  = isrLevel_q;
  assign selected   = selected_q;
`ifdef AEOI_EN
  assign auto_eoi   = autoEoi_q;
`endif

endmodule

// File: tb/tb_cascade_slave_responder.sv
// tb_cascade_slave_responder
// Directed bench for the slave INTA sequencer, built with a 16-clock gap
// timeout. Define AEOI_EN to also exercise the automatic-EOI pulse.
module tb_cascade_slave_responder;

  logic       clk;
  logic       reset;
  logic       inta_n;
  logic       sp_neg;
  logic       single_mode_flag;
  logic       mode_8086;
  logic [2:0] my_slave_id;
  logic [2:0] cascading_lines;
  logic       int_pending;
  logic [2:0] int_level;
  logic [7:0] icw2;
  logic [2:0] icw1_addr;
  logic [7:0] data_out;
  logic       data_drive;
  logic       isr_set;
  logic [2:0] isr_level;
  logic       selected;
`ifdef AEOI_EN
  logic       aeoi_flag;
  logic       auto_eoi;
`endif

  int testsRun = 0;
  int failures = 0;

  cascade_slave_responder #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .inta_n           (inta_n),
    .sp_neg           (sp_neg),
    .single_mode_flag (single_mode_flag),
    .mode_8086        (mode_8086),
    .my_slave_id      (my_slave_id),
    .cascading_lines  (cascading_lines),
    .int_pending      (int_pending),
    .int_level        (int_level),
    .icw2             (icw2),
    .icw1_addr        (icw1_addr),
    .data_out         (data_out),
    .data_drive       (data_drive),
    .isr_set          (isr_set),
    .isr_level        (isr_level),
`ifdef AEOI_EN
    .aeoi_flag        (aeoi_flag),
    .auto_eoi         (auto_eoi),
`endif
    .selected         (selected)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mode, input logic [2:0] slaveId,
                               input logic [2:0] casc, input logic pend,
                               input logic [2:0] level, input logic [7:0] vec,
                               input logic [2:0] addr);
    mode_8086       = mode;
    my_slave_id     = slaveId;
    cascading_lines = casc;
    int_pending     = pend;
    int_level       = level;
    icw2            = vec;
    icw1_addr       = addr;
  endtask

  // Drive INTA low; the fall is detected on the next edge.
  task automatic fallEdge();
    inta_n = 1'b0;
    tick(1);
  endtask

  // Hold INTA low one more clock, then release; the rise is detected on the next edge.
  task automatic riseEdge();
    tick(1);
    inta_n = 1'b1;
    tick(1);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
      end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {7'd0, observed}, {7'd0, expected});
  endtask

  initial begin
    reset            = 1'b1;
    inta_n           = 1'b1;
    sp_neg           = 1'b0;
    single_mode_flag = 1'b0;
`ifdef AEOI_EN
    aeoi_flag        = 1'b0;
`endif
    applyStimulus(1'b1, 3'd3, 3'd3, 1'b1, 3'd5, 8'h40, 3'd0);
    tick(3);

    // Reset state
    checkOutput("rst_data_out", data_out, 8'h00);
    checkBit("rst_data_drive", data_drive, 1'b0);
    checkBit("rst_isr_set", isr_set, 1'b0);
    checkOutput("rst_isr_level", {5'd0, isr_level}, 8'h00);
    checkBit("rst_selected", selected, 1'b0);
`ifdef AEOI_EN
    checkBit("rst_auto_eoi", auto_eoi, 1'b0);
`endif
    reset = 1'b0;
    tick(2);

    // 8086 hit; level and mode changed mid-sequence must be ignored
    fallEdge();
    checkBit("hit86_p1_drive", data_drive, 1'b0);
    checkBit("hit86_p1_sel", selected, 1'b0);
    riseEdge();
    checkBit("hit86_isr_set", isr_set, 1'b1);
    checkBit("hit86_sel", selected, 1'b1);
    checkOutput("hit86_level", {5'd0, isr_level}, 8'h05);
    checkBit("hit86_g1_drive", data_drive, 1'b0);
    int_level = 3'd7;
    mode_8086 = 1'b0;
    tick(1);
    checkBit("hit86_isr_set_width", isr_set, 1'b0);
    fallEdge();
    checkBit("hit86_p2_drive", data_drive, 1'b1);
    checkOutput("hit86_p2_data", data_out, 8'h45);
    riseEdge();
    checkBit("hit86_end_drive", data_drive, 1'b0);
    checkOutput("hit86_end_data", data_out, 8'h00);
    checkBit("hit86_end_sel", selected, 1'b0);
    tick(2);

    // 8086 miss: cascade code belongs to another slave
    applyStimulus(1'b1, 3'd3, 3'd2, 1'b1, 3'd5, 8'h40, 3'd0);
    fallEdge();
    riseEdge();
    checkBit("miss86_isr_set", isr_set, 1'b0);
    checkBit("miss86_sel", selected, 1'b0);
    tick(1);
    fallEdge();
    checkBit("miss86_p2_drive", data_drive, 1'b0);
    checkOutput("miss86_p2_data", data_out, 8'h00);
    riseEdge();
    tick(2);

    // 8080 hit; also proves the miss left the sequencer aligned in IDLE
    applyStimulus(1'b0, 3'd3, 3'd3, 1'b1, 3'd2, 8'h12, 3'b101);
    fallEdge();
    riseEdge();
    checkBit("hit80_isr_set", isr_set, 1'b1);
    checkOutput("hit80_level", {5'd0, isr_level}, 8'h02);
    tick(1);
    fallEdge();
    checkBit("hit80_p2_drive", data_drive, 1'b1);
    checkOutput("hit80_p2_data", data_out, 8'hA8);
    riseEdge();
    checkBit("hit80_g2_drive", data_drive, 1'b0);
    checkBit("hit80_g2_sel", selected, 1'b1);
    tick(1);
    fallEdge();
    checkBit("hit80_p3_drive", data_drive, 1'b1);
    checkOutput("hit80_p3_data", data_out, 8'h12);
    riseEdge();
    checkBit("hit80_end_drive", data_drive, 1'b0);
    checkBit("hit80_end_sel", selected, 1'b0);
    tick(2);

    // Gap timeout at 16 idle clocks, then a new pulse starts a fresh P1
    applyStimulus(1'b1, 3'd3, 3'd3, 1'b1, 3'd5, 8'h40, 3'd0);
    fallEdge();
    riseEdge();
    checkBit("to_sel_start", selected, 1'b1);
    tick(15);
    checkBit("to_sel_gap15", selected, 1'b1);
    tick(1);
    checkBit("to_sel_gap16", selected, 1'b0);
    tick(4);
    int_level = 3'd6;
    fallEdge();
    checkBit("to_newp1_drive", data_drive, 1'b0);
    riseEdge();
    checkBit("to_newp1_isr_set", isr_set, 1'b1);
    checkOutput("to_newp1_level", {5'd0, isr_level}, 8'h06);
    tick(1);
    fallEdge();
    checkOutput("to_p2_data", data_out, 8'h46);
    riseEdge();
    tick(2);

    // Reset asserted during P2 with the bus driven
    int_level = 3'd5;
    fallEdge();
    riseEdge();
    tick(1);
    fallEdge();
    checkBit("rp2_drive_before", data_drive, 1'b1);
    reset = 1'b1;
    #1;
    checkBit("rp2_drive_async", data_drive, 1'b0);
    checkOutput("rp2_data_async", data_out, 8'h00);
    checkBit("rp2_sel_async", selected, 1'b0);
    checkOutput("rp2_level_async", {5'd0, isr_level}, 8'h00);
    inta_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    checkBit("rp2_after_drive", data_drive, 1'b0);
    checkBit("rp2_after_sel", selected, 1'b0);

    // Master mode: same hit stimulus, everything stays quiet
    sp_neg = 1'b1;
    fallEdge();
    riseEdge();
    checkBit("mst_isr_set", isr_set, 1'b0);
    checkBit("mst_sel", selected, 1'b0);
    tick(1);
    fallEdge();
    checkBit("mst_drive", data_drive, 1'b0);
    checkOutput("mst_data", data_out, 8'h00);
    riseEdge();
    sp_neg = 1'b0;
    tick(2);

    // Single mode raised mid-sequence forces IDLE on the next clock
    fallEdge();
    riseEdge();
    checkBit("inert_sel_before", selected, 1'b1);
    single_mode_flag = 1'b1;
    tick(1);
    checkBit("inert_sel_after", selected, 1'b0);
    checkOutput("inert_level_after", {5'd0, isr_level}, 8'h00);
    single_mode_flag = 1'b0;
    tick(2);

`ifdef AEOI_EN
    // Automatic EOI after the final 8086 pulse
    aeoi_flag = 1'b1;
    fallEdge();
    riseEdge();
    tick(1);
    fallEdge();
    checkBit("aeoi_p2", auto_eoi, 1'b0);
    riseEdge();
    checkBit("aeoi_pulse", auto_eoi, 1'b1);
    tick(1);
    checkBit("aeoi_width", auto_eoi, 1'b0);
    tick(1);
    aeoi_flag = 1'b0;
    fallEdge();
    riseEdge();
    tick(1);
    fallEdge();
    riseEdge();
    checkBit("aeoi_off", auto_eoi, 1'b0);
    tick(2);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
